wb_arbiter: RTL

- Writeback scheduler for the register-file write port.
- Arbitrates three result sources: ALU result, memory load return and control-unit sign-extended immediate.
- Drives the writeback mux select (00 ALU, 01 MEM, 10 IMM, 11 idle/disconnect), RF write enable and write address.
- Tracks one outstanding load with a latency counter and stalls conflicting writes to the load's destination register.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback scheduler for the register-file write port.
// Arbitrates ALU results, a single outstanding memory load and control-unit
// immediates onto one RF write port. Memory writeback has absolute priority;
// ALU and IMM share the remaining cycles round-robin.
// wb_sel encoding: 00 ALU, 01 MEM, 10 IMM, 11 idle.
// Optional build macro WB_R0_ZERO_EN: r0 is hardwired to zero. Writes to r0
// are suppressed, and r0 never takes part in the load hazard match.
module wb_arbiter #(
    parameter int REG_AW  = 3,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_req,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic              imm_req,
    input  logic [REG_AW-1:0] imm_rd,
    input  logic              mem_req,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              mem_ack,
    output logic              load_busy,
    output logic              alu_gnt,
    output logic              imm_gnt,
    output logic              hazard_stall,
    output logic [1:0]        wb_sel,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_WB} state_t;
    typedef enum logic {RR_ALU, RR_IMM} rr_t;

    state_t            state;
    state_t            next_state;
    rr_t               rr_ptr;
    logic [CNT_W-1:0]  counter;
    logic [REG_AW-1:0] load_rd;

    logic              hazard_window;
    logic              load_rd_matchable;
    logic              alu_blk;
    logic              imm_blk;
    logic              alu_elig;
    logic              imm_elig;
    logic              alu_win;
    logic              imm_win;
    logic              accept;
    logic              grant_ok;
    logic [1:0]        sel_n;
    logic              we_n;
    logic [REG_AW-1:0] waddr_n;

    // Hazard detection, next-state, arbitration and next write-port values
    always_comb begin
`ifdef WB_R0_ZERO_EN
        load_rd_matchable = (load_rd != '0);
`else
        load_rd_matchable = 1'b1;
`endif
        hazard_window = load_busy && (state != LOAD_WB) && load_rd_matchable;
        alu_blk       = hazard_window && (alu_rd == load_rd);
        imm_blk       = hazard_window && (imm_rd == load_rd);

        accept     = 1'b0;
        next_state = state;
        case (state)
            IDLE, LOAD_WB: begin
                if (mem_req) begin
                    accept     = 1'b1;
                    next_state = (MEM_LAT == 1) ? LOAD_WB : LOAD_WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            LOAD_WAIT: begin
                if (counter == '0) begin
                    next_state = LOAD_WB;
                end
            end
            default: next_state = IDLE;
        endcase

        // The memory write cycle belongs to the load alone
        grant_ok = (next_state != LOAD_WB);
        alu_elig = alu_req && !alu_gnt && !alu_blk;
        imm_elig = imm_req && !imm_gnt && !imm_blk;
        alu_win  = grant_ok && alu_elig && (!imm_elig || (rr_ptr == RR_ALU));
        imm_win  = grant_ok && imm_elig && !alu_win;

        sel_n   = 2'b11;
        we_n    = 1'b0;
        waddr_n = rf_waddr;
        if (next_state == LOAD_WB) begin
            sel_n   = 2'b01;
            we_n    = 1'b1;
            waddr_n = accept ? mem_rd : load_rd;
        end else if (alu_win) begin
            sel_n   = 2'b00;
            we_n    = 1'b1;
            waddr_n = alu_rd;
        end else if (imm_win) begin
            sel_n   = 2'b10;
            we_n    = 1'b1;
            waddr_n = imm_rd;
        end
`ifdef WB_R0_ZERO_EN
        if (waddr_n == '0) begin
            we_n = 1'b0;
        end
`endif
    end

    assign hazard_stall = (alu_req && alu_blk) || (imm_req && imm_blk);

    // Load FSM, round-robin pointer and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= RR_ALU;
            counter   <= '0;
            load_rd   <= '0;
            wb_sel    <= 2'b11;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            alu_gnt   <= 1'b0;
            imm_gnt   <= 1'b0;
            mem_ack   <= 1'b0;
            load_busy <= 1'b0;
        end else begin
            state     <= next_state;
            mem_ack   <= accept;
            load_busy <= (next_state != IDLE);
            if (accept) begin
                load_rd <= mem_rd;
                counter <= CNT_W'(MEM_LAT - 1);
            end else if ((state == LOAD_WAIT) && (counter != '0)) begin
                counter <= counter - CNT_W'(1);
            end
            if (alu_win) begin
                rr_ptr <= RR_IMM;
            end else if (imm_win) begin
                rr_ptr <= RR_ALU;
            end
            alu_gnt  <= alu_win;
            imm_gnt  <= imm_win;
            wb_sel   <= sel_n;
            rf_we    <= we_n;
            rf_waddr <= waddr_n;
        end
    end

endmodule
